// File: rtl/one_hot_seq_pkg.sv
// Shared types and helpers for the one-hot position sequencer.
// The optional checker is enabled with ONE_HOT_SEQ_CHECK_EN.
package one_hot_seq_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  // Wide enough for any legal index (N up to 64).
  localparam int MAX_CW = 6;

  typedef struct packed {
    logic [MAX_CW-1:0] idx;
    logic              atTerm;
    logic              landsTerm;
  } step_t;

  function automatic int idxWidth(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // atTerm: the current index is already the terminal for this direction,
  // so idx is the wrapped value; landsTerm: the step arrives on the terminal.
  function automatic step_t nextIndex(input logic [MAX_CW-1:0] idx,
                                      input logic              dir,
                                      input int unsigned       n);
    step_t             s;
    logic [MAX_CW-1:0] last;
    last = MAX_CW'(n - 1);
    s    = '0;
    if (dir == DIR_UP) begin
      s.atTerm    = (idx == last);
      s.idx       = s.atTerm ? '0 : idx + MAX_CW'(1);
      s.landsTerm = (s.idx == last);
    end else begin
      s.atTerm    = (idx == '0);
      s.idx       = s.atTerm ? last : idx - MAX_CW'(1);
      s.landsTerm = (s.idx == '0);
    end
    return s;
  endfunction

endpackage

// File: rtl/one_hot_seq_if.sv
// Handshake and status bundle between a controller and one_hot_seq.
interface one_hot_seq_if
  import one_hot_seq_pkg::*;
#(
  parameter int N = 8
) ();

  localparam int CW = idxWidth(N);

  logic          go;
  logic          hold;
  logic          dir;
  logic          wrap;
  logic          load;
  logic [CW-1:0] load_idx;
  logic [CW-1:0] count;
  logic [N-1:0]  one_hot;
  logic          busy;
  logic          done;

  modport master (
    output go, hold, dir, wrap, load, load_idx,
    input  count, one_hot, busy, done
  );

  modport slave (
    input  go, hold, dir, wrap, load, load_idx,
    output count, one_hot, busy, done
  );

endinterface

// File: rtl/one_hot_seq_dec.sv
// Binary index to N-bit one-hot decoder used by one_hot_seq.
module one_hot_dec
  import one_hot_seq_pkg::*;
#(
  parameter  int N  = 8,
  localparam int CW = idxWidth(N)
) (
  input  logic [CW-1:0] idx_i,
  output logic [N-1:0]  onehot_o
);

  always_comb begin
    onehot_o = N'(1) << idx_i;
  end

endmodule

// File: rtl/one_hot_seq.sv
// One-hot position sequencer: wrap or one-shot runs with preload and done pulse.
// Define ONE_HOT_SEQ_CHECK_EN to add the sticky err output.
module one_hot_seq
  import one_hot_seq_pkg::*;
#(
  parameter int N = 8
) (
  input  logic          clk,
  input  logic          nreset,
  one_hot_seq_if.slave  bus
`ifdef ONE_HOT_SEQ_CHECK_EN
  ,
  output logic          err
`endif
);

  localparam int CW = idxWidth(N);

  state_t        state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic          wrap_q, wrap_d;
  logic          done_q, done_d;
  logic [N-1:0]  oneHot;
  step_t         step;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q <= IDLE;
      count_q <= '0;
      wrap_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      wrap_q  <= wrap_d;
      done_q  <= done_d;
    end
  end

  // In one-shot mode a run that starts on the terminal ends without stepping.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    wrap_d  = wrap_q;
    done_d  = 1'b0;
    step    = nextIndex(MAX_CW'(count_q), bus.dir, N);
    case (state_q)
      IDLE: begin
        if (bus.load) begin
          count_d = (int'(bus.load_idx) >= N) ? CW'(N - 1) : bus.load_idx;
        end
        if (bus.go) begin
          state_d = RUN;
          wrap_d  = bus.wrap;
        end
      end
      RUN: begin
        if (!bus.hold) begin
          if (wrap_q) begin
            if (bus.go) begin
              count_d = CW'(step.idx);
              done_d  = step.atTerm;
            end else begin
              state_d = IDLE;
            end
          end else if (step.atTerm) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            count_d = CW'(step.idx);
            if (step.landsTerm) begin
              done_d  = 1'b1;
              state_d = IDLE;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  one_hot_dec #(.N(N)) uDec (
    .idx_i    (count_q),
    .onehot_o (oneHot)
  );

  assign bus.count   = count_q;
  assign bus.one_hot = oneHot;
  assign bus.busy    = (state_q == RUN);
  assign bus.done    = done_q;

`ifdef ONE_HOT_SEQ_CHECK_EN
  logic         err_q, err_d;
  logic [N-1:0] seen;

  // Watches the driven one_hot, so any corruption after the decoder is caught.
  always_comb begin
    seen  = bus.one_hot;
    err_d = err_q;
    if ((seen == '0) || ((seen & (seen - N'(1))) != '0) || (seen != oneHot)) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err = err_q;
`endif

endmodule

// File: doc/one_hot_seq.md
# one_hot_seq

Parametrised one-hot position sequencer: a binary index register and its one-hot decode step up or down across N positions under a go/hold handshake. Supports free-running wrap mode and one-shot run-to-terminal mode, with preload and a per-run done pulse. Serves as the generalised replacement for the fixed 8-position one-hot counter used in link-state and lane-select sequencing.

## Interface
- N, 8, number of one-hot positions; legal range 2..64.
- CW, max(1,$clog2(N)), index width; derived, never overridden.
- clk  in  1  rising-edge clock.
- nreset  in  1  asynchronous active-low reset.
- go  in  1  start request in IDLE; in wrap mode, keep-running level.
- hold  in  1  stall: no step on an edge where hold=1 in RUN.
- dir  in  1  0 = up (index+1), 1 = down (index-1); sampled on every step.
- wrap  in  1  1 = wrap mode, 0 = one-shot; sampled only on the IDLE->RUN edge.
- load  in  1  preload strobe, honoured in IDLE only.
- load_idx  in  CW  preload index.
- count  out  CW  current index.
- one_hot  out  N  decode of count, always equal to 1<<count.
- busy  out  1  1 while in RUN.
- done  out  1  single-cycle terminal/wrap pulse.
- Clocking and reset: one clock; reset is asynchronous and active-low.

## Operation
- States: IDLE, RUN. Wrap mode is latched into an internal bit at the start of a run.
- Reset: state IDLE, count=0, one_hot=1, busy=0, done=0, latched wrap=0.
- IDLE, load=1: count<=load_idx; if load_idx>=N, count<=N-1 (saturate).
- IDLE, go=1: state<=RUN, busy<=1, wrap latched. If load and go occur in the same cycle, the load applies and the run starts from the loaded index.
- RUN, hold=1: no change. Hold overrides everything except reset.
- RUN, hold=0, one-shot: steps one position per edge in direction dir.
  - On the edge where count reaches the terminal (N-1 up, 0 down): done=1, state<=IDLE, busy<=0 on that same edge.
  - If already at the terminal on the first RUN edge: no step; done=1 and return to IDLE on that edge.
  - go is ignored after the start.
- RUN, hold=0, wrap mode, go=1: steps, wrapping N-1->0 (up) or 0->N-1 (down). done pulses on each edge that wraps.
- RUN, wrap mode, go=0 (sampled with hold=0): no step; state<=IDLE, busy<=0; position is retained.
- load is ignored in RUN.
- A dir change mid-run takes effect on the next step.
- Asynchronous reset mid-run returns immediately to reset values.

## Timing
- All outputs are registered; no combinational input-to-output paths.
- go sampled high at edge k: busy=1 after k; first step at edge k+1 (if hold=0).
- One-shot, N=8, up from 0, no hold: steps at edges k+1..k+7; done=1 and busy=0 after k+7.
- done is high for exactly one cycle per event.
- Each cycle of hold extends the run by one cycle.

## Configuration
- ONE_HOT_SEQ_CHECK_EN defined: adds output port err (1 bit, reset 0).
  - err is set sticky when one_hot is not exactly one-hot or does not match the decode of count.
  - err clears only on reset.
- ONE_HOT_SEQ_CHECK_EN undefined: no err port and no checking logic; the rest of the behaviour is identical.

## Structure
- Package one_hot_seq_pkg holds:
  - the state typedef (IDLE, RUN);
  - DIR_UP/DIR_DOWN constants;
  - a helper function computing next index with wrap/terminal flags.
- Sub-module one_hot_dec (parametrised N: CW-bit index -> N-bit one-hot) drives one_hot, and feeds the compare in the check logic.

## Test plan
- Reset: hold nreset=0, pulse go -> count=0, one_hot=8'b00000001, busy=0, done=0. Release reset -> outputs unchanged.
- One-shot up, N=8: go for 1 cycle, wrap=0, dir=0 -> count 1..7 on consecutive edges; done pulses once with count=7, one_hot=8'b10000000; busy falls on the same edge.
- Wrap down with hold: load_idx=2, dir=1, wrap=1, go held, hold=1 for 2 cycles mid-run.
  - Sequence is 2,1,0,7,6 with two repeated values during the hold.
  - done pulses on the 0->7 edge.
  - Dropping go gives IDLE with count retained.
- Preload saturation: N=6, load_idx=7 -> count=5, one_hot=6'b100000. A following one-shot up run gives done on the first edge with no step.
- Mid-run reset: assert nreset=0 while count=4 in RUN -> count=0, busy=0 immediately, without waiting for a clock edge.
- With ONE_HOT_SEQ_CHECK_EN: force one_hot to 8'b00000110 -> err=1 next cycle, stays 1 after the force is released until reset.
